// File: rtl/imem_loader.sv
// imem_loader: fills instruction RAM from a length/data/checksum byte stream.
// Holds the core in reset until a load completes cleanly.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [WIDTH-1:0]  iram_din,
    output logic              iram_wren,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loadState_e;

    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    loadState_e        state;
    loadState_e        nextState;
    logic [ADDR_W:0]   wordCnt;
    logic [ADDR_W:0]   cntNext;
    logic [15:0]       nWords;
    logic [7:0]        lenLo;
    logic [1:0]        lane;
    logic [WIDTH-1:0]  wordReg;
    logic [7:0]        csumAcc;
    logic [16:0]       lenFull;
    logic              accept;
    logic              canStart;
    logic              lastWord;

    assign accept   = rx_valid && rx_ready;
    assign canStart = start && (state == IDLE || state == DONE ||
                                state == ERR);
    assign lenFull  = {1'b0, rx_data, lenLo};
    assign cntNext  = wordCnt + (ADDR_W+1)'(1);
    assign lastWord = 17'(cntNext) == {1'b0, nWords};

    assign iram_addr = wordCnt[ADDR_W-1:0];
    assign iram_din  = wordReg;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (accept) nextState = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (lenFull > MaxWords)
                        nextState = ERR;
                    else if (lenFull == 17'd0)
                        nextState = CSUM;
                    else
                        nextState = DATA;
                end
            end
            DATA: begin
                if (accept && lane == 2'd3) nextState = WRITE;
            end
            WRITE: begin
                nextState = lastWord ? CSUM : DATA;
            end
            CSUM: begin
                if (accept)
                    nextState = (rx_data == csumAcc) ? DONE : ERR;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        iram_wren = 1'b0;
        core_hold = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state)
            IDLE: ;
            LEN_LO, LEN_HI, DATA, CSUM: begin
                rx_ready  = 1'b1;
                core_hold = 1'b1;
            end
            WRITE: begin
                iram_wren = 1'b1;
                core_hold = 1'b1;
            end
            DONE: done = 1'b1;
            ERR: begin
                error     = 1'b1;
                core_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Checksum covers every byte before the checksum itself.
    always_ff @(posedge clock) begin
        if (clear) begin
            wordCnt <= '0;
            nWords  <= '0;
            lenLo   <= '0;
            lane    <= '0;
            wordReg <= '0;
            csumAcc <= '0;
        end else begin
            if (canStart) begin
                wordCnt <= '0;
                lane    <= '0;
                csumAcc <= '0;
            end
            if (accept && state != CSUM)
                csumAcc <= csumAcc ^ rx_data;
            if (accept && state == LEN_LO)
                lenLo <= rx_data;
            if (accept && state == LEN_HI)
                nWords <= {rx_data, lenLo};
            if (accept && state == DATA) begin
                wordReg[{lane, 3'b000} +: 8] <= rx_data;
                lane <= lane + 2'd1;
            end
            if (state == WRITE)
                wordCnt <= cntNext;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: model predicts writes and
// outcome per stream; a monitor checks every IRAM write strobe.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] iram_addr;
    logic [31:0]   iram_din;
    logic          iram_wren;
    logic          core_hold;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_W(AW), .WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .iram_addr(iram_addr), .iram_din(iram_din),
        .iram_wren(iram_wren), .core_hold(core_hold),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic holdPrev = 1'b0;
    always @(negedge clock) holdPrev <= core_hold;

    int nCmp = 0;
    int nBad = 0;

    logic [7:0]  stream[$];
    logic [31:0] words[$];
    int          expAddr[$];
    logic [31:0] expData[$];
    int          expOut;
    int          sCyc;

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next prediction.
    always @(negedge clock) begin
        int a;
        logic [31:0] d;
        if (iram_wren === 1'b1) begin
            check("ready_in_write", 64'(rx_ready), 64'd0);
            if (expAddr.size() == 0) begin
                nCmp++;
                nBad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         iram_addr, iram_din);
            end else begin
                a = expAddr.pop_front();
                d = expData.pop_front();
                check("write_addr", 64'(iram_addr), 64'(a));
                check("write_data", 64'(iram_din), 64'(d));
            end
        end
    end

    task automatic mkStream(int n, logic [7:0] flip);
        logic [7:0] x;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++)
                stream.push_back(8'(words[i] >> (8 * b)));
        end
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(x ^ flip);
    endtask

    // Reference: parse the stream and predict writes for whole words sent.
    task automatic buildModel(int nSent);
        int n;
        logic [7:0] x;
        expAddr.delete();
        expData.delete();
        expOut = 0;
        n = {stream[1], stream[0]};
        if (n > (1 << AW)) begin
            if (nSent >= 2) expOut = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (2 + 4 * i + 4 <= nSent) begin
                expAddr.push_back(i);
                expData.push_back({stream[2 + 4 * i + 3],
                                   stream[2 + 4 * i + 2],
                                   stream[2 + 4 * i + 1],
                                   stream[2 + 4 * i]});
            end
        end
        if (nSent == stream.size()) begin
            x = 8'h00;
            for (int j = 0; j < nSent - 1; j++) x ^= stream[j];
            expOut = (x == stream[nSent - 1]) ? 1 : 2;
        end
    endtask

    task automatic doStart();
        @(negedge clock);
        start = 1'b1;
        sCyc = cyc;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send(int nSend, int gapPct, bit startNoise);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < nSend) begin
            @(negedge clock);
            rx_valid = ($urandom_range(99) >= gapPct);
            rx_data = rx_valid ? stream[i] : 8'($urandom);
            start = startNoise && ($urandom_range(7) == 0);
            acc = rx_valid && rx_ready;
            @(posedge clock);
            #1;
            start = 1'b0;
            rx_valid = 1'b0;
            if (acc) i++;
            guard++;
            if (guard > nSend * 20 + 50) begin
                nCmp++;
                nBad++;
                $display("FAIL send_timeout: got %0d bytes expected %0d",
                         i, nSend);
                break;
            end
        end
    endtask

    task automatic finishLoad(bit chkTime);
        int t;
        for (t = 0; t < 6; t++) begin
            @(negedge clock);
            if (done || error) break;
        end
        check("result_latency", 64'(t), 64'd0);
        check("outcome", 64'({done, error}),
              64'(expOut == 1 ? 2'b10 : 2'b01));
        check("hold_after", 64'(core_hold), 64'(expOut == 2));
        check("writes_pending", 64'(expAddr.size()), 64'd0);
        if (chkTime) begin
            check("done_cycle", 64'(cyc - sCyc), 64'd14);
            check("hold_before_done", 64'(holdPrev), 64'd1);
        end
    endtask

    task automatic randWords(int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic checkZero(string name);
        check(name, 64'({rx_ready, iram_addr, iram_din, iram_wren,
                         core_hold, done, error}), 64'd0);
    endtask

    initial begin
        int n;
        clear = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkZero("reset_outputs");
        clear = 1'b0;

        words = {32'h00500093, 32'h00100113};
        mkStream(2, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 0, 0);
        finishLoad(1);

        mkStream(2, 8'h01);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 0, 0);
        finishLoad(0);

        mkStream(2, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 0, 0);
        finishLoad(0);

        stream = {8'h01, 8'h01};
        buildModel(2);
        doStart();
        send(2, 0, 0);
        finishLoad(0);

        words.delete();
        mkStream(0, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 0, 0);
        finishLoad(0);

        randWords(3);
        mkStream(3, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 30, 1);
        finishLoad(0);

        randWords(3);
        mkStream(3, 8'h00);
        buildModel(8);
        doStart();
        send(8, 0, 1);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checkZero("clear_outputs");
        check("clear_writes_pending", 64'(expAddr.size()), 64'd0);

        randWords(3);
        mkStream(3, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 10, 1);
        finishLoad(0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            randWords(n);
            mkStream(n, ($urandom_range(1) == 1) ?
                        8'($urandom_range(1, 255)) : 8'h00);
            buildModel(stream.size());
            doStart();
            send(stream.size(), 20, 1);
            finishLoad(0);
        end

        randWords(1 << AW);
        mkStream(1 << AW, 8'h00);
        buildModel(stream.size());
        doStart();
        send(stream.size(), 0, 0);
        finishLoad(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
